pe_agu_ctrl: RTL and testbench

// Instruction sequencer in front of one PE's address-generation unit (pe_agu).
// - Queues AGU instructions, pulses the AGU start, and waits for the AGU done.
// - Owns the index ping-pong buffer: it decides when switch_idx_buf fires and

---
 rtl/pe_agu_ctrl.sv | 156 +++++++++++++++
 tb/tb_pe_agu_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_agu_ctrl.sv
// Instruction sequencer for one PE's AGU: queues instructions, issues start pulses,
// waits for done, and owns the index ping-pong bank handshake.
module pe_agu_ctrl #(
    parameter int QDEPTH = 4,
    parameter int TO_W   = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [1:0]       ins_mode,
    input  logic [7:0]       ins_idx_cnt,
    input  logic [7:0]       ins_trip_cnt,
    input  logic             ins_is_new,
    input  logic [3:0]       ins_pad_code,
    input  logic             ins_cut_y,
    input  logic             ins_new_idx,
    output logic             idx_load_ready,
    input  logic             idx_load_done,
    output logic             agu_start,
    output logic [1:0]       agu_mode,
    output logic [7:0]       agu_idx_cnt,
    output logic [7:0]       agu_trip_cnt,
    output logic             agu_is_new,
    output logic [3:0]       agu_pad_code,
    output logic             agu_cut_y,
    input  logic             agu_done,
    output logic             switch_idx_buf,
    output logic             busy,
    output logic [CNT_W-1:0] ins_done_cnt,
    output logic [1:0]       err
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int EW = 25;
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [PW:0]     Q_FULL  = (PW+1)'(QDEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWITCH,
        S_START,
        S_HOLD,
        S_RUN
    } state_t;

    logic [EW-1:0]    q_mem [QDEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ready_q;
    logic             wr_full_q, wr_full_d;
    state_t           state_q, state_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] done_cnt_q;
    logic [1:0]       err_q, err_d;
    logic [EW-2:0]    agu_word_q;

    logic          push, pop, done_inc, to_evt, switching;
    logic [EW-1:0] in_word, head;

    assign in_word   = {ins_mode, ins_idx_cnt, ins_trip_cnt, ins_is_new,
                        ins_pad_code, ins_cut_y, ins_new_idx};
    assign head      = q_mem[rd_ptr_q];
    assign push      = ins_valid & ready_q;
    assign switching = (state_q == S_SWITCH);
    assign cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

    // A load pulse arriving in the same cycle as a swap refills the bank just freed.
    assign wr_full_d = idx_load_done | (wr_full_q & ~switching);
    assign err_d     = err_q | {idx_load_done & wr_full_q & ~switching, to_evt};

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        pop      = 1'b0;
        done_inc = 1'b0;
        to_evt   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                wd_d = '0;
                // A load completing this cycle lets a waiting new_idx head go at once.
                if (cnt_q != '0) begin
                    if (!head[0]) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else if (wr_full_q | idx_load_done) begin
                        pop     = 1'b1;
                        state_d = S_SWITCH;
                    end
                end
            end
            S_SWITCH: state_d = S_START;
            S_START:  state_d = S_HOLD;
            S_HOLD: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_q + 1'b1;
                if (agu_done) begin
                    done_inc = 1'b1;
                    state_d  = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    to_evt  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_q] <= in_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            wr_full_q  <= 1'b0;
            state_q    <= S_IDLE;
            wd_q       <= '0;
            done_cnt_q <= '0;
            err_q      <= '0;
            agu_word_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                agu_word_q <= head[EW-1:1];
            end
            cnt_q     <= cnt_d;
            ready_q   <= (cnt_d != Q_FULL);
            wr_full_q <= wr_full_d;
            state_q   <= state_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            if (done_inc) done_cnt_q <= done_cnt_q + 1'b1;
        end
    end

    assign ins_ready      = ready_q;
    assign idx_load_ready = ~wr_full_q;
    assign agu_start      = (state_q == S_START);
    assign switch_idx_buf = switching;
    assign busy           = (state_q != S_IDLE) | (cnt_q != '0);
    assign ins_done_cnt   = done_cnt_q;
    assign err            = err_q;
    assign {agu_mode, agu_idx_cnt, agu_trip_cnt, agu_is_new, agu_pad_code, agu_cut_y} = agu_word_q;

endmodule

// File: tb/tb_pe_agu_ctrl.sv
// Bench for pe_agu_ctrl: random and directed instruction traffic checked every cycle
// against a timestamp-based model of issue, switch, completion and timeout times.
module tb_pe_agu_ctrl;

    localparam int QD     = 4;
    localparam int TW     = 5;
    localparam int CW     = 16;
    // Last cycle (relative to start) on which the RUN watchdog can still accept done.
    localparam int TO_END = 2 + (2**TW - 1) - 1;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] idx;
        logic [7:0] trip;
        logic       is_new;
        logic [3:0] pad;
        logic       cut_y;
        logic       new_idx;
    } fld_t;

    typedef struct {
        fld_t f;
        int   lat;
    } ent_t;

    logic          clk, rst;
    logic          ins_valid, ins_ready;
    logic [1:0]    ins_mode;
    logic [7:0]    ins_idx_cnt, ins_trip_cnt;
    logic          ins_is_new, ins_cut_y, ins_new_idx;
    logic [3:0]    ins_pad_code;
    logic          idx_load_ready, idx_load_done;
    logic          agu_start;
    logic [1:0]    agu_mode;
    logic [7:0]    agu_idx_cnt, agu_trip_cnt;
    logic          agu_is_new, agu_cut_y;
    logic [3:0]    agu_pad_code;
    logic          agu_done, switch_idx_buf, busy;
    logic [CW-1:0] ins_done_cnt;
    logic [1:0]    err;

    pe_agu_ctrl #(.QDEPTH(QD), .TO_W(TW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_mode(ins_mode), .ins_idx_cnt(ins_idx_cnt), .ins_trip_cnt(ins_trip_cnt),
        .ins_is_new(ins_is_new), .ins_pad_code(ins_pad_code), .ins_cut_y(ins_cut_y),
        .ins_new_idx(ins_new_idx),
        .idx_load_ready(idx_load_ready), .idx_load_done(idx_load_done),
        .agu_start(agu_start), .agu_mode(agu_mode), .agu_idx_cnt(agu_idx_cnt),
        .agu_trip_cnt(agu_trip_cnt), .agu_is_new(agu_is_new), .agu_pad_code(agu_pad_code),
        .agu_cut_y(agu_cut_y), .agu_done(agu_done),
        .switch_idx_buf(switch_idx_buf), .busy(busy),
        .ins_done_cnt(ins_done_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: instructions in flight are described by their timestamps.
    ent_t       m_q[$];
    ent_t       m_cur;
    bit         m_act, m_sw, m_to, m_bank;
    int         m_pop, m_start, m_end, m_cnt;
    logic [1:0] m_err;

    // AGU environment: raises done lat cycles after the start it observes.
    int lat_q[$];
    bit a_act;
    int a_start, a_lat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic ent_t mk(input bit nidx, input int lat);
        ent_t e;
        e.f         = 25'($urandom);
        e.f.new_idx = nidx;
        e.lat       = lat;
        return e;
    endfunction

    function automatic int rnd_lat();
        if ($urandom_range(0, 9) == 0) return 0;
        return int'($urandom_range(3, 40));
    endfunction

    task automatic model_reset();
        m_q.delete();
        lat_q.delete();
        m_act = 0; m_sw = 0; m_to = 0; m_bank = 0;
        m_pop = 0; m_start = 0; m_end = 0; m_cnt = 0; m_err = 2'b00;
        a_act = 0; a_start = 0; a_lat = 0;
    endtask

    task automatic step(input bit v, input ent_t e, input bit ld, output bit acc);
        int   t;
        bit   ready_now, sw_now;
        fld_t cf;
        @(negedge clk);
        cyc++;
        t  = cyc;
        cf = m_cur.f;
        check_val("agu_start", 32'(agu_start), 32'(m_act && t == m_start));
        check_val("switch", 32'(switch_idx_buf), 32'(m_act && m_sw && t == m_pop + 1));
        check_val("busy", 32'(busy), 32'(m_act || m_q.size() != 0));
        check_val("ins_ready", 32'(ins_ready), 32'(m_q.size() < QD));
        check_val("ld_ready", 32'(idx_load_ready), 32'(!m_bank));
        check_val("done_cnt", 32'(ins_done_cnt), 32'(m_cnt));
        check_val("err", 32'(err), 32'(m_err));
        if (m_act && t == m_start)
            check_val("fields", 32'({agu_mode, agu_idx_cnt, agu_trip_cnt, agu_is_new,
                                      agu_pad_code, agu_cut_y}), 32'(cf[24:1]));
        if (agu_start) begin
            a_act   = 1;
            a_start = t;
            a_lat   = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
        end
        agu_done = !a_act || (t <= a_start + 1) || (a_lat != 0 && t >= a_start + a_lat);

        ins_valid = v;
        {ins_mode, ins_idx_cnt, ins_trip_cnt, ins_is_new, ins_pad_code, ins_cut_y,
         ins_new_idx} = e.f;
        idx_load_done = ld;

        ready_now = (m_q.size() < QD);
        sw_now    = m_act && m_sw && (t == m_pop + 1);
        if (!m_act && m_q.size() != 0) begin
            if (!m_q[0].f.new_idx || m_bank || ld) begin
                m_cur   = m_q.pop_front();
                m_sw    = m_cur.f.new_idx;
                m_pop   = t;
                m_start = t + 1 + (m_sw ? 1 : 0);
                if (m_cur.lat != 0 && m_cur.lat <= TO_END) begin
                    m_end = m_start + m_cur.lat;
                    m_to  = 0;
                end else begin
                    m_end = m_start + TO_END;
                    m_to  = 1;
                end
                m_act = 1;
            end
        end else if (m_act && t == m_end) begin
            if (m_to) m_err[0] = 1'b1;
            else      m_cnt++;
            m_act = 0;
        end
        if (ld && m_bank && !sw_now) m_err[1] = 1'b1;
        m_bank = ld ? 1'b1 : (sw_now ? 1'b0 : m_bank);
        acc = v && ready_now;
        if (acc) begin
            m_q.push_back(e);
            lat_q.push_back(e.lat);
        end
    endtask

    task automatic idle(input int n);
        bit   a;
        ent_t z;
        z.f   = '0;
        z.lat = 0;
        for (int i = 0; i < n; i++) step(0, z, 0, a);
    endtask

    task automatic push_one(input ent_t e);
        bit a;
        int k;
        a = 0;
        k = 0;
        while (!a && k < 300) begin
            step(1, e, 0, a);
            k++;
        end
        if (!a) check_val("push_bound", 32'(ins_ready), 32'(1));
    endtask

    task automatic wait_idle(input int maxc);
        bit   a, need_ld;
        int   k;
        ent_t z;
        z.f   = '0;
        z.lat = 0;
        k     = 0;
        while ((m_act || m_q.size() != 0) && k < maxc) begin
            need_ld = !m_act && m_q.size() != 0 && m_q[0].f.new_idx && !m_bank;
            step(0, z, need_ld, a);
            k++;
        end
        if (m_act || m_q.size() != 0) check_val("idle_bound", 32'(busy), 32'(0));
    endtask

    initial begin
        bit   a;
        int   k;
        ent_t e, z;
        z.f   = '0;
        z.lat = 0;
        rst = 1'b0;
        ins_valid = 0; idx_load_done = 0; agu_done = 1'b1;
        {ins_mode, ins_idx_cnt, ins_trip_cnt, ins_is_new, ins_pad_code, ins_cut_y,
         ins_new_idx} = '0;
        model_reset();
        idle(3);
        rst = 1'b1;

        // single conv instruction, done 20 cycles after start
        e = mk(0, 20);
        e.f.mode = 2'b00;
        e.f.idx  = 8'd8;
        push_one(e);
        wait_idle(200);
        idle(2);
        check_val("A_cnt", 32'(ins_done_cnt), 32'(1));
        check_val("A_busy", 32'(busy), 32'(0));

        // five back-to-back pushes fill the queue
        for (int i = 0; i < 5; i++) push_one(mk(0, int'($urandom_range(3, 12))));
        wait_idle(400);
        idle(1);
        check_val("B_cnt", 32'(ins_done_cnt), 32'(6));

        // new_idx waits for a load 10 cycles later
        push_one(mk(1, 15));
        idle(9);
        step(0, z, 1, a);
        wait_idle(200);
        idle(1);
        check_val("C_ldr", 32'(idx_load_ready), 32'(1));

        // double load without a swap
        step(0, z, 1, a);
        idle(3);
        step(0, z, 1, a);
        idle(1);
        check_val("D_err", 32'(err), 32'(2));
        check_val("D_ldr", 32'(idx_load_ready), 32'(0));
        push_one(mk(0, 5));
        push_one(mk(1, 5));
        wait_idle(200);

        // AGU never answers, then a normal instruction follows
        push_one(mk(0, 0));
        push_one(mk(0, 6));
        wait_idle(300);
        idle(1);
        check_val("E_err", 32'(err), 32'(3));
        check_val("E_cnt", 32'(ins_done_cnt), 32'(10));

        // random traffic
        for (int i = 0; i < 600; i++) begin
            e = mk($urandom_range(0, 2) == 0, rnd_lat());
            step($urandom_range(0, 2) == 0, e, $urandom_range(0, 5) == 0, a);
        end
        wait_idle(3000);

        // asynchronous reset while RUN
        push_one(mk(0, 30));
        k = 0;
        while (!(m_act && cyc >= m_start + 6) && k < 100) begin
            step(0, z, 0, a);
            k++;
        end
        #2 rst = 1'b0;
        #1;
        check_val("R_start", 32'(agu_start), 32'(0));
        check_val("R_busy", 32'(busy), 32'(0));
        check_val("R_ready", 32'(ins_ready), 32'(1));
        check_val("R_ldr", 32'(idx_load_ready), 32'(1));
        check_val("R_cnt", 32'(ins_done_cnt), 32'(0));
        check_val("R_err", 32'(err), 32'(0));
        model_reset();
        agu_done = 1'b1;
        idle(2);
        rst = 1'b1;
        idle(3);
        check_val("R2_busy", 32'(busy), 32'(0));
        check_val("R2_cnt", 32'(ins_done_cnt), 32'(0));
        push_one(mk(0, 4));
        wait_idle(100);
        idle(1);
        check_val("R2_done", 32'(ins_done_cnt), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
